// File: rtl/wasm_cpu.sv
// WebAssembly stack-machine core: two-cycle FETCH/EXEC over a wide ROM read, 16-entry typed stack.
// Optional operand type checking is enabled by defining WASM_CPU_TYPECHECK_EN.
module wasm_cpu #(
    parameter int HAS_FPU   = 1,
    parameter int USE_64B   = 1,
    parameter int MEM_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [63:0]          result,
    output logic [1:0]           result_type,
    output logic                 result_empty,
    output logic [3:0]           trap,
    output logic [MEM_DEPTH:0]   mem_addr,
    output logic [3:0]           mem_extra,
    input  logic [127:0]         mem_data,
    input  logic                 mem_error
);
    localparam int AW = MEM_DEPTH + 1;

    typedef enum logic { S_FETCH, S_EXEC } state_t;
    typedef enum logic [1:0] { TY_I32, TY_I64, TY_F32, TY_F64 } ty_t;
    typedef enum logic [3:0] {
        T_NONE, T_ENDED, T_UNREACH, T_UNKNOWN, T_UNDER, T_OVER, T_TYPE, T_NO64, T_NOFPU, T_MEM
    } trap_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [4:0]    sp_q, sp_d;
    trap_t         trap_q, trap_d;
    logic [63:0]   stk_val_q [16];
    logic [1:0]    stk_ty_q  [16];

    logic          wr_en;
    logic [3:0]    wr_idx;
    logic [63:0]   wr_val;
    ty_t           wr_ty;

    logic [7:0]    opcode;
    logic [3:0]    ia, ib, ilen;
    logic          is64, isfpu, known, push, binop, drop, op64, mismatch;
    logic [4:0]    npop;
    logic [63:0]   pval, alu_a, alu_b, alu_r, leb32_v, leb64_v;
    ty_t           pty;
    int unsigned   n32, n64;
    logic          unused_hi;

    // Length of a LEB128 field in bytes 1.. of the fetch: first byte without continuation bit.
    function automatic int unsigned leb_len(input logic [127:0] d, input int unsigned maxlen);
        int unsigned n;
        logic        found;
        n = maxlen;
        found = 1'b0;
        for (int unsigned k = 0; k < 10; k++) begin
            if (k < maxlen && !found && !d[8*k+15]) begin
                n = k + 1;
                found = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [63:0] leb_val(input logic [127:0] d, input int unsigned n);
        logic [63:0] v;
        logic        sgn;
        sgn = d[8*n+6];
        for (int unsigned i = 0; i < 64; i++) begin
            v[i] = (i / 7 < n) ? d[8*(i/7) + 8 + (i%7)] : sgn;
        end
        return v;
    endfunction

    assign opcode    = mem_data[7:0];
    assign unused_hi = ^mem_data[127:88];
    assign ib        = sp_q[3:0] - 4'd1;
    assign ia        = sp_q[3:0] - 4'd2;
    assign alu_a     = stk_val_q[ia];
    assign alu_b     = stk_val_q[ib];

    assign mem_addr     = pc_q;
    assign mem_extra    = 4'd10;
    assign trap         = trap_q;
    assign result_empty = (sp_q == 5'd0);
    assign result       = result_empty ? 64'd0 : stk_val_q[ib];
    assign result_type  = result_empty ? 2'd0 : stk_ty_q[ib];

`ifdef WASM_CPU_TYPECHECK_EN
    logic [1:0] want_ty;
    assign want_ty  = op64 ? 2'd1 : 2'd0;
    assign mismatch = binop && ((stk_ty_q[ia] != want_ty) || (stk_ty_q[ib] != want_ty));
`else
    assign mismatch = 1'b0;
`endif

    always_comb begin
        n32     = leb_len(mem_data, 5);
        n64     = leb_len(mem_data, 10);
        leb32_v = leb_val(mem_data, n32);
        leb64_v = leb_val(mem_data, n64);
        is64 = 1'b0; isfpu = 1'b0; known = 1'b1; push = 1'b0; binop = 1'b0;
        drop = 1'b0; op64 = 1'b0; npop = 5'd0; ilen = 4'd1; pval = '0; pty = TY_I32;
        case (opcode)
            8'h00, 8'h01, 8'h0B: ;
            8'h1A: begin drop = 1'b1; npop = 5'd1; end
            8'h41: begin push = 1'b1; pval = {32'd0, leb32_v[31:0]}; ilen = 4'd1 + 4'(n32); end
            8'h42: begin
                push = 1'b1; is64 = 1'b1; pty = TY_I64; pval = leb64_v; ilen = 4'd1 + 4'(n64);
            end
            8'h43: begin
                push = 1'b1; isfpu = 1'b1; pty = TY_F32; pval = {32'd0, mem_data[39:8]}; ilen = 4'd5;
            end
            8'h44: begin
                push = 1'b1; isfpu = 1'b1; is64 = 1'b1; pty = TY_F64; pval = mem_data[71:8]; ilen = 4'd9;
            end
            8'h6A, 8'h6B, 8'h71, 8'h72, 8'h73: begin binop = 1'b1; npop = 5'd2; end
            8'h7C, 8'h7D, 8'h83, 8'h84, 8'h85: begin
                binop = 1'b1; npop = 5'd2; op64 = 1'b1; is64 = 1'b1;
            end
            default: known = 1'b0;
        endcase

        case (opcode)
            8'h6A, 8'h7C: alu_r = alu_a + alu_b;
            8'h6B, 8'h7D: alu_r = alu_a - alu_b;
            8'h71, 8'h83: alu_r = alu_a & alu_b;
            8'h72, 8'h84: alu_r = alu_a | alu_b;
            default:      alu_r = alu_a ^ alu_b;
        endcase
        if (!op64) alu_r = {32'd0, alu_r[31:0]};
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        trap_d  = trap_q;
        wr_en   = 1'b0;
        wr_idx  = sp_q[3:0];
        wr_val  = '0;
        wr_ty   = TY_I32;
        if (trap_q == T_NONE) begin
            if (state_q == S_FETCH) begin
                state_d = S_EXEC;
            end else begin
                state_d = S_FETCH;
                // Chain order encodes trap priority; UNREACHABLE/ENDED are the instructions' own effects.
                if (mem_error)                    trap_d = T_MEM;
                else if (USE_64B == 0 && is64)   trap_d = T_NO64;
                else if (HAS_FPU == 0 && isfpu)  trap_d = T_NOFPU;
                else if (!known)                 trap_d = T_UNKNOWN;
                else if (sp_q < npop)            trap_d = T_UNDER;
                else if (mismatch)               trap_d = T_TYPE;
                else if (push && sp_q == 5'd16)  trap_d = T_OVER;
                else if (opcode == 8'h00)        trap_d = T_UNREACH;
                else if (opcode == 8'h0B)        trap_d = T_ENDED;
                else begin
                    pc_d = pc_q + AW'(ilen);
                    if (push) begin
                        wr_en = 1'b1; wr_idx = sp_q[3:0]; wr_val = pval; wr_ty = pty;
                        sp_d = sp_q + 5'd1;
                    end else if (binop) begin
                        wr_en = 1'b1; wr_idx = ia; wr_val = alu_r; wr_ty = op64 ? TY_I64 : TY_I32;
                        sp_d = sp_q - 5'd1;
                    end else if (drop) begin
                        sp_d = sp_q - 5'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            sp_q    <= '0;
            trap_q  <= T_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            trap_q  <= trap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            stk_val_q[wr_idx] <= wr_val;
            stk_ty_q[wr_idx]  <= wr_ty;
        end
    end
endmodule

// File: tb/tb_wasm_cpu.sv
// Self-checking bench for wasm_cpu: directed programs plus random programs against a queue-based model.
module tb_wasm_cpu;
    localparam int MD = 6;
    localparam int AW = MD + 1;
`ifdef WASM_CPU_TYPECHECK_EN
    localparam bit TC = 1'b1;
`else
    localparam bit TC = 1'b0;
`endif

    typedef struct packed { logic [63:0] v; logic [1:0] t; } ent_t;
    typedef struct packed { logic [7:0] op; logic [63:0] v; } insn_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] rom [128];
    int         rom_len = 0;
    logic [7:0] prog [$];
    int         n_checks = 0;
    int         n_err = 0;

    logic [63:0]   r0, r1, r2;
    logic [1:0]    rt0, rt1, rt2;
    logic          e0, e1, e2;
    logic [3:0]    t0, t1, t2, x0, x1, x2;
    logic [AW-1:0] a0, a1, a2;
    logic [127:0]  md0 = '0, md1 = '0, md2 = '0;
    logic          me0 = 1'b0, me1 = 1'b0, me2 = 1'b0;

    wasm_cpu #(.HAS_FPU(1), .USE_64B(1), .MEM_DEPTH(MD)) dut (
        .clk(clk), .reset(reset), .result(r0), .result_type(rt0), .result_empty(e0), .trap(t0),
        .mem_addr(a0), .mem_extra(x0), .mem_data(md0), .mem_error(me0));
    wasm_cpu #(.HAS_FPU(1), .USE_64B(0), .MEM_DEPTH(MD)) dut_n64 (
        .clk(clk), .reset(reset), .result(r1), .result_type(rt1), .result_empty(e1), .trap(t1),
        .mem_addr(a1), .mem_extra(x1), .mem_data(md1), .mem_error(me1));
    wasm_cpu #(.HAS_FPU(0), .USE_64B(1), .MEM_DEPTH(MD)) dut_nfpu (
        .clk(clk), .reset(reset), .result(r2), .result_type(rt2), .result_empty(e2), .trap(t2),
        .mem_addr(a2), .mem_extra(x2), .mem_data(md2), .mem_error(me2));

    function automatic logic [127:0] rd(input logic [AW-1:0] a);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) begin
            if (int'(a) + k < 128) v[8*k +: 8] = rom[int'(a) + k];
        end
        return v;
    endfunction

    // ROM collaborator: one-cycle registered read, error when the first byte is past the program
    always @(posedge clk) begin
        md0 <= rd(a0); me0 <= (int'(a0) >= rom_len);
        md1 <= rd(a1); me1 <= (int'(a1) >= rom_len);
        md2 <= rd(a2); me2 <= (int'(a2) >= rom_len);
    end

    task automatic start();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 128; i++) rom[i] = (i < prog.size()) ? prog[i] : 8'h00;
        rom_len = prog.size();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic leb(input logic signed [63:0] val);
        logic signed [63:0] v;
        logic [7:0]         b;
        bit                 done;
        v = val;
        done = 1'b0;
        while (!done) begin
            b = {1'b0, v[6:0]};
            v = v >>> 7;
            if ((v == 64'sd0 && !b[6]) || (v == -64'sd1 && b[6])) done = 1'b1;
            else b[7] = 1'b1;
            prog.push_back(b);
        end
    endtask

    task automatic test_reset();
        prog = '{8'h01, 8'h01};
        start();
        #1;
        n_checks++; if (t0 !== 4'd0) begin n_err++; $display("FAIL reset_trap got %0d want 0", t0); end
        n_checks++; if (e0 !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", e0); end
        n_checks++; if (r0 !== 64'd0 || rt0 !== 2'd0) begin n_err++; $display("FAIL reset_result got %h/%0d want 0/0", r0, rt0); end
        n_checks++; if (a0 !== '0 || x0 !== 4'd10) begin n_err++; $display("FAIL reset_mem got addr %0d extra %0d want 0/10", a0, x0); end
        run(2);
        n_checks++; if (a0 !== 7'd1) begin n_err++; $display("FAIL nop_pc got %0d want 1", a0); end
    endtask

    task automatic test_i64_add();
        prog = '{8'h42, 8'h01, 8'h42, 8'h02, 8'h7C, 8'h0B};
        start();
        run(7);
        n_checks++; if (t0 !== 4'd0 || r0 !== 64'd3) begin n_err++; $display("FAIL i64_cyc7 got trap %0d res %h want 0/3", t0, r0); end
        run(1);
        n_checks++; if (t0 !== 4'd1) begin n_err++; $display("FAIL i64_end got %0d want 1", t0); end
        run(4);
        n_checks++; if (r0 !== 64'd3 || rt0 !== 2'd1 || e0 !== 1'b0 || t0 !== 4'd1) begin
            n_err++; $display("FAIL i64_final got %h/%0d/%b/%0d want 3/1/0/1", r0, rt0, e0, t0); end
        n_checks++; if (t1 !== 4'd7 || e1 !== 1'b1) begin n_err++; $display("FAIL no64 got %0d/%b want 7/1", t1, e1); end
    endtask

    task automatic test_i32_add();
        prog = '{8'h41, 8'h7F, 8'h41, 8'h02, 8'h6A, 8'h0B};
        start();
        run(8);
        n_checks++; if (r0 !== 64'd1 || rt0 !== 2'd0 || t0 !== 4'd1) begin
            n_err++; $display("FAIL i32_add got %h/%0d/%0d want 1/0/1", r0, rt0, t0); end
    endtask

    task automatic test_traps();
        prog = '{8'h6A}; start(); run(2);
        n_checks++; if (t0 !== 4'd4) begin n_err++; $display("FAIL underflow got %0d want 4", t0); end
        prog = '{8'h00}; start(); run(1);
        n_checks++; if (t0 !== 4'd0) begin n_err++; $display("FAIL unreach_early got %0d want 0", t0); end
        run(1);
        n_checks++; if (t0 !== 4'd2) begin n_err++; $display("FAIL unreach got %0d want 2", t0); end
        prog = '{8'hFF}; start(); run(2);
        n_checks++; if (t0 !== 4'd3) begin n_err++; $display("FAIL unknown got %0d want 3", t0); end
        prog = '{8'h01}; start(); run(4);
        n_checks++; if (t0 !== 4'd9) begin n_err++; $display("FAIL mem_error got %0d want 9", t0); end
    endtask

    task automatic test_fpu();
        prog = '{8'h43, 8'h00, 8'h00, 8'h80, 8'h3F, 8'h0B};
        start();
        run(4);
        n_checks++; if (r0 !== 64'h3F80_0000 || rt0 !== 2'd2) begin n_err++; $display("FAIL f32 got %h/%0d want 3f800000/2", r0, rt0); end
        n_checks++; if (t2 !== 4'd8) begin n_err++; $display("FAIL nofpu got %0d want 8", t2); end
    endtask

    task automatic test_overflow();
        prog.delete();
        for (int i = 0; i < 17; i++) begin prog.push_back(8'h41); prog.push_back(8'h00); end
        prog.push_back(8'h0B);
        start();
        run(33);
        n_checks++; if (t0 !== 4'd0) begin n_err++; $display("FAIL overflow_early got %0d want 0", t0); end
        run(1);
        n_checks++; if (t0 !== 4'd5 || e0 !== 1'b0) begin n_err++; $display("FAIL overflow got %0d/%b want 5/0", t0, e0); end
    endtask

    task automatic test_typecheck_reset();
        prog = '{8'h41, 8'h01, 8'h42, 8'h01, 8'h7C};
        start();
        run(6);
        if (TC) begin
            n_checks++; if (t0 !== 4'd6 || r0 !== 64'd1 || rt0 !== 2'd1) begin
                n_err++; $display("FAIL typecheck got %0d/%h/%0d want 6/1/1", t0, r0, rt0); end
        end else begin
            n_checks++; if (r0 !== 64'd2 || rt0 !== 2'd1) begin
                n_err++; $display("FAIL notypecheck got %h/%0d want 2/1", r0, rt0); end
            run(2);
            n_checks++; if (t0 !== 4'd9) begin n_err++; $display("FAIL notc_memerr got %0d want 9", t0); end
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (e0 !== 1'b1 || t0 !== 4'd0 || a0 !== '0) begin
            n_err++; $display("FAIL trap_reset got %b/%0d/%0d want 1/0/0", e0, t0, a0); end
        @(negedge clk); reset = 1'b0;
        run(2);
        n_checks++; if (r0 !== 64'd1 || rt0 !== 2'd0 || e0 !== 1'b0) begin
            n_err++; $display("FAIL restart got %h/%0d/%b want 1/0/0", r0, rt0, e0); end
    endtask

    task automatic test_reset_mid();
        prog = '{8'h42, 8'h01, 8'h42, 8'h02, 8'h7C, 8'h0B};
        start();
        run(3);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (e0 !== 1'b1 || a0 !== '0) begin n_err++; $display("FAIL reset_mid got %b/%0d want 1/0", e0, a0); end
        @(negedge clk); reset = 1'b0;
        run(8);
        n_checks++; if (r0 !== 64'd3 || t0 !== 4'd1) begin n_err++; $display("FAIL reset_mid_rerun got %h/%0d want 3/1", r0, t0); end
    endtask

    task automatic test_random();
        logic [7:0]         ops [10];
        ent_t               st [$];
        insn_t              ins [$];
        ent_t               ea, eb;
        logic [31:0]        v32;
        logic signed [63:0] v64;
        logic [63:0]        res;
        logic [7:0]         op;
        logic [3:0]         etrap;
        int                 r, nins, n, cyc;
        bit                 w64;
        ops = '{8'h6A, 8'h6B, 8'h71, 8'h72, 8'h73, 8'h7C, 8'h7D, 8'h83, 8'h84, 8'h85};
        for (int it = 0; it < 40; it++) begin
            prog.delete(); ins.delete(); st.delete();
            nins = $urandom_range(1, 24);
            for (int i = 0; i < nins && prog.size() < 100; i++) begin
                r = $urandom_range(0, 99);
                if (r < 30) begin
                    v32 = (r < 10) ? 32'($urandom_range(0, 200)) - 32'd100 : $urandom;
                    prog.push_back(8'h41); leb({{32{v32[31]}}, v32});
                    ins.push_back(insn_t'{8'h41, {32'd0, v32}});
                end else if (r < 50) begin
                    v64 = {$urandom, $urandom};
                    v64 = v64 >>> $urandom_range(0, 63);
                    prog.push_back(8'h42); leb(v64);
                    ins.push_back(insn_t'{8'h42, v64});
                end else if (r < 55) begin
                    v32 = $urandom;
                    prog.push_back(8'h43);
                    for (int k = 0; k < 4; k++) prog.push_back(v32[8*k +: 8]);
                    ins.push_back(insn_t'{8'h43, {32'd0, v32}});
                end else if (r < 60) begin
                    v64 = {$urandom, $urandom};
                    prog.push_back(8'h44);
                    for (int k = 0; k < 8; k++) prog.push_back(v64[8*k +: 8]);
                    ins.push_back(insn_t'{8'h44, v64});
                end else begin
                    op = (r < 66) ? 8'h1A : (r < 69) ? 8'h01 : (r < 70) ? 8'h00 : (r < 71) ? 8'h20
                       : ops[$urandom_range(0, 9)];
                    prog.push_back(op);
                    ins.push_back(insn_t'{op, 64'd0});
                end
            end
            prog.push_back(8'h0B);
            ins.push_back(insn_t'{8'h0B, 64'd0});

            etrap = 4'd0; n = 0;
            foreach (ins[i]) begin
                if (etrap == 4'd0) begin
                    n++;
                    op = ins[i].op;
                    case (op)
                        8'h00: etrap = 4'd2;
                        8'h01: ;
                        8'h0B: etrap = 4'd1;
                        8'h1A: if (st.size() < 1) etrap = 4'd4; else void'(st.pop_back());
                        8'h41, 8'h42, 8'h43, 8'h44:
                            if (st.size() == 16) etrap = 4'd5;
                            else st.push_back(ent_t'{ins[i].v, 2'(op - 8'h41)});
                        8'h6A, 8'h6B, 8'h71, 8'h72, 8'h73, 8'h7C, 8'h7D, 8'h83, 8'h84, 8'h85: begin
                            w64 = (op >= 8'h7C);
                            if (st.size() < 2) etrap = 4'd4;
                            else begin
                                eb = st[$]; ea = st[$-1];
                                if (TC && (ea.t != {1'b0, w64} || eb.t != {1'b0, w64})) etrap = 4'd6;
                                else begin
                                    void'(st.pop_back()); void'(st.pop_back());
                                    case (op)
                                        8'h6A, 8'h7C: res = ea.v + eb.v;
                                        8'h6B, 8'h7D: res = ea.v - eb.v;
                                        8'h71, 8'h83: res = ea.v & eb.v;
                                        8'h72, 8'h84: res = ea.v | eb.v;
                                        default:      res = ea.v ^ eb.v;
                                    endcase
                                    if (!w64) res = res & 64'hFFFF_FFFF;
                                    st.push_back(ent_t'{res, {1'b0, w64}});
                                end
                            end
                        end
                        default: etrap = 4'd3;
                    endcase
                end
            end

            start();
            cyc = 0;
            while (t0 == 4'd0 && cyc < 600) begin
                @(posedge clk); #1;
                cyc++;
            end
            n_checks++; if (t0 !== etrap) begin n_err++; $display("FAIL rand%0d_trap got %0d want %0d", it, t0, etrap); end
            n_checks++; if (cyc != 2 * n) begin n_err++; $display("FAIL rand%0d_cycles got %0d want %0d", it, cyc, 2 * n); end
            n_checks++; if (e0 !== (st.size() == 0)) begin n_err++; $display("FAIL rand%0d_empty got %b want %b", it, e0, st.size() == 0); end
            if (st.size() > 0) begin
                n_checks++; if (r0 !== st[$].v || rt0 !== st[$].t) begin
                    n_err++; $display("FAIL rand%0d_top got %h/%0d want %h/%0d", it, r0, rt0, st[$].v, st[$].t); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_i64_add();
        test_i32_add();
        test_traps();
        test_fpu();
        test_overflow();
        test_typecheck_reset();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
